udp_tx_buffer: RTL and testbench

//  Payload staging buffer and send sequencer directly upstream of the Ethernet TX chain.

---
 rtl/udp_tx_buffer.sv | 178 +++++++++++++++++
 tb/tb_udp_tx_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_buffer.sv
// udp_tx_buffer: payload staging RAM plus per-frame send sequencer for the
// Ethernet TX chain. Whole payloads are written on the din side, committed
// on din_last, and replayed one frame at a time through fs/fifo_rxen/fd.
// Optional macro UDP_TX_PAD_EN: short payloads are reported as MIN_LEN bytes
// long and zero-filled past their real end.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | no frame in flight, waiting for a committed payload
// LOAD        | latch head length into data_len / byte down-counter
// SEND        | fs high, serving byte pulls until fd
// WAIT_FD_LOW | frame done, wait for fd release, then skip unread bytes
module udp_tx_buffer #(
    parameter int AW      = 11,
    parameter int LQ_AW   = 2,
    parameter int MAX_LEN = 1472,
    parameter int MIN_LEN = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_last,
    output logic        din_ready,
    output logic        drop,
    output logic        fs,
    input  logic        fd,
    output logic [15:0] data_len,
    input  logic        fifo_rxen,
    output logic [7:0]  fifo_rxd,
    output logic        busy
);

    localparam int PW  = AW + 1;
    localparam int LQW = LQ_AW + 1;
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
`ifdef UDP_TX_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_FD_LOW} state_t;

    state_t state, state_nxt;

    logic [7:0]  ram [2**AW];
    logic [15:0] lq_mem [2**LQ_AW];

    logic [PW-1:0]  wr_ptr, commit_ptr, rd_ptr, frame_end;
    logic [LQW-1:0] lq_wr_ptr, lq_rd_ptr;
    logic [15:0]    wlen;
    logic [15:0]    remaining;
    logic           dropping;

    logic        ram_full, lq_full, lq_empty;
    logic        accept, over_len, wr_en, commit;
    logic        pull, rd_step, retire;
    logic [15:0] lq_head, load_len;

    assign ram_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign lq_full  = (lq_wr_ptr[LQ_AW] != lq_rd_ptr[LQ_AW]) &&
                      (lq_wr_ptr[LQ_AW-1:0] == lq_rd_ptr[LQ_AW-1:0]);
    assign lq_empty = (lq_wr_ptr == lq_rd_ptr);

    assign din_ready = ~rst & ~ram_full & ~lq_full;
    assign accept    = din_valid & din_ready;
    assign over_len  = accept & ~dropping & (wlen == MAX_LEN_W);
    assign wr_en     = accept & ~dropping & ~over_len;
    assign commit    = wr_en & din_last;

    // The head entry stays occupied until its frame retires, so the queue
    // bounds frames outstanding including the one in flight.
    assign lq_head  = lq_mem[lq_rd_ptr[LQ_AW-1:0]];
    assign load_len = (PAD_EN && (lq_head < MIN_LEN_W)) ? MIN_LEN_W : lq_head;

    assign pull    = fifo_rxen & (state == SEND);
    assign rd_step = pull & (remaining != 16'd0);
    assign retire  = (state == WAIT_FD_LOW) & ~fd;

    // Payload byte storage, no reset needed
    always_ff @(posedge clk) begin
        if (wr_en) ram[wr_ptr[AW-1:0]] <= din;
    end

    // Committed payload lengths
    always_ff @(posedge clk) begin
        if (commit) lq_mem[lq_wr_ptr[LQ_AW-1:0]] <= wlen + 16'd1;
    end

    // Write side: pointer, running length, commit and oversize discard
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            wlen       <= '0;
            dropping   <= 1'b0;
            drop       <= 1'b0;
            lq_wr_ptr  <= '0;
        end else begin
            drop <= over_len;
            if (over_len) begin
                // rewind over the partial payload; swallow the rest unless this byte ends it
                wr_ptr   <= commit_ptr;
                wlen     <= '0;
                dropping <= ~din_last;
            end else if (accept && dropping) begin
                if (din_last) dropping <= 1'b0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
                if (din_last) begin
                    commit_ptr <= wr_ptr + PW'(1);
                    wlen       <= '0;
                    lq_wr_ptr  <= lq_wr_ptr + LQW'(1);
                end else begin
                    wlen <= wlen + 16'd1;
                end
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Read FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (!lq_empty) state_nxt = LOAD;
            LOAD:        state_nxt = SEND;
            SEND:        if (fd) state_nxt = WAIT_FD_LOW;
            WAIT_FD_LOW: if (!fd) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        fs   = (state == SEND);
        busy = (state != IDLE);
    end

    // Read datapath: frame length, byte down-counter, read pointer, pull data
    always_ff @(posedge clk) begin
        if (rst) begin
            data_len  <= '0;
            remaining <= '0;
            frame_end <= '0;
            rd_ptr    <= '0;
            lq_rd_ptr <= '0;
            fifo_rxd  <= '0;
        end else begin
            if (state == LOAD) begin
                data_len  <= load_len;
                remaining <= lq_head;
                frame_end <= rd_ptr + PW'(lq_head);
            end
            if (pull) begin
                if (rd_step) begin
                    fifo_rxd  <= ram[rd_ptr[AW-1:0]];
                    rd_ptr    <= rd_ptr + PW'(1);
                    remaining <= remaining - 16'd1;
                end else begin
                    fifo_rxd <= 8'h00;
                end
            end
            if (retire) begin
                rd_ptr    <= frame_end;
                lq_rd_ptr <= lq_rd_ptr + LQW'(1);
            end
        end
    end

endmodule

// File: tb/tb_udp_tx_buffer.sv
// tb_udp_tx_buffer: scoreboard bench for udp_tx_buffer. Payload bytes and
// expected lengths are queued as they are written; a TX-side model pulls
// each frame and compares against the queues.
module tb_udp_tx_buffer;

    logic        clk = 1'b0;
    logic        rst, din_valid, din_last, fd, fifo_rxen;
    logic [7:0]  din;
    logic        din_ready, drop, fs, busy;
    logic [15:0] data_len;
    logic [7:0]  fifo_rxd;

    int n_checks = 0;
    int n_errors = 0;
    int drop_cnt, drop_idx;

    byte unsigned exp_bytes[$];
    int           exp_len[$];
    int           exp_real[$];

    udp_tx_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .drop      (drop),
        .fs        (fs),
        .fd        (fd),
        .data_len  (data_len),
        .fifo_rxen (fifo_rxen),
        .fifo_rxd  (fifo_rxd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pad_len(input int n);
`ifdef UDP_TX_PAD_EN
        return (n < 18) ? 18 : n;
`else
        return n;
`endif
    endfunction

    function automatic int pay_byte(input int kind, input int i);
        if (kind == 0) return (i + 1) & 255;
        if (kind == 1) return 8'hAA;
        return int'($urandom_range(0, 255));
    endfunction

    task automatic write_payload(input int n, input int kind, input bit sent, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int b;
            int w;
            b = pay_byte(kind, i);
            w = 0;
            while (!din_ready && w < 200) begin
                tick();
                w++;
            end
            if (!din_ready) begin
                chk("din_ready_wait", din_ready, 1);
                return;
            end
            din       = 8'(b);
            din_valid = 1'b1;
            din_last  = with_last && (i == n - 1);
            tick();
            din_valid = 1'b0;
            din_last  = 1'b0;
            if (drop) begin
                drop_cnt++;
                drop_idx = i + 1;
            end
            if (sent) exp_bytes.push_back(8'(b));
        end
        if (sent && with_last) begin
            exp_real.push_back(n);
            exp_len.push_back(pad_len(n));
        end
    endtask

    task automatic wait_fs(output bit ok);
        int w;
        w = 0;
        while (!fs && w < 3) begin
            tick();
            w++;
        end
        ok = fs;
        chk("fs_start", fs, 1);
    endtask

    // Serve one whole frame: data_len, every pull (plus extra pulls past the end), fd handshake.
    task automatic serve(input int extra);
        bit ok;
        int dl, rl;
        logic [31:0] e;
        wait_fs(ok);
        dl = exp_len.pop_front();
        rl = exp_real.pop_front();
        if (!ok) begin
            for (int i = 0; i < rl; i++) void'(exp_bytes.pop_front());
            return;
        end
        chk("data_len", data_len, dl);
        for (int i = 0; i < dl + extra; i++) begin
            fifo_rxen = 1'b1;
            tick();
            e = (i < rl) ? 32'(exp_bytes.pop_front()) : 32'h0;
            chk("rxd", fifo_rxd, e);
        end
        fifo_rxen = 1'b0;
        fd = 1'b1;
        tick();
        chk("fs_fall", fs, 0);
        chk("busy_fd", busy, 1);
        fd = 1'b0;
        tick();
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1; din = '0; din_valid = 1'b0; din_last = 1'b0;
        fd = 1'b0; fifo_rxen = 1'b0;
        drop_cnt = 0; drop_idx = 0;

        // reset values
        tick();
        chk("rst_din_ready", din_ready, 0);
        chk("rst_fs", fs, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_len", data_len, 0);
        chk("rst_rxd", fifo_rxd, 0);
        chk("rst_drop", drop, 0);
        rst = 1'b0;
        tick();
        chk("din_ready_after_rst", din_ready, 1);

        // 1) 64-byte counting payload, one pull past the end returns zero
        write_payload(64, 0, 1, 1);
        serve(1);

        // 2) four 100-byte payloads fill the length queue while frame 1 is held
        for (int k = 0; k < 4; k++) write_payload(100, 2, 1, 1);
        chk("lq_full_ready", din_ready, 0);
        serve(0);
        chk("ready_after_retire", din_ready, 1);
        for (int k = 0; k < 3; k++) serve(0);

        // 3) oversize payload dropped on byte 1473, terminated by a discarded last byte
        drop_cnt = 0;
        write_payload(1473, 0, 0, 0);
        chk("drop_count", drop_cnt, 1);
        chk("drop_index", drop_idx, 1473);
        write_payload(1, 0, 0, 1);
        chk("drop_count_tail", drop_cnt, 1);
        repeat (5) tick();
        chk("drop_no_fs", fs, 0);
        chk("drop_no_busy", busy, 0);
        chk("drop_ready", din_ready, 1);
        write_payload(10, 2, 1, 1);
        serve(0);

        // 4) short payload, padded length depends on build
        write_payload(5, 1, 1, 1);
        serve(0);

        // 5) reset in the middle of a frame
        write_payload(30, 0, 1, 1);
        wait_fs(ok);
        chk("mid_data_len", data_len, 30);
        for (int i = 0; i < 20; i++) begin
            fifo_rxen = 1'b1;
            tick();
            chk("mid_rxd", fifo_rxd, 32'(exp_bytes.pop_front()));
        end
        fifo_rxen = 1'b0;
        rst = 1'b1;
        tick();
        chk("mid_rst_fs", fs, 0);
        chk("mid_rst_busy", busy, 0);
        rst = 1'b0;
        exp_bytes.delete();
        exp_len.delete();
        exp_real.delete();
        repeat (4) tick();
        chk("post_rst_no_fs", fs, 0);
        chk("post_rst_no_busy", busy, 0);
        write_payload(8, 2, 1, 1);
        serve(0);

        // 6) 1500 bytes as three payloads, drain, then 1000 bytes across the wrap
        for (int k = 0; k < 3; k++) write_payload(500, 2, 1, 1);
        for (int k = 0; k < 3; k++) serve(0);
        write_payload(1000, 2, 1, 1);
        serve(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
